// File: rtl/cordic_gain_scale.sv
// Three-stage valid/ready scaler: multiplies a signed X/Y pair by the constant COEF/2^COEF_FRAC
// using sign-magnitude shift-add arithmetic with round-half-away-from-zero; per-pair bypass.
module cordic_gain_scale #(
    parameter int WIDTH     = 8,
    parameter int COEF      = 39797,
    parameter int COEF_FRAC = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             In_Bypass,
    input  logic [WIDTH-1:0] In_X,
    input  logic [WIDTH-1:0] In_Y,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_X,
    output logic [WIDTH-1:0] Out_Y
);

    localparam int PW = WIDTH + COEF_FRAC;
    localparam logic [COEF_FRAC-1:0] COEF_V = COEF_FRAC'(COEF);
    localparam logic [PW-1:0] HALF = PW'(1) << (COEF_FRAC - 1);

    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Constant coefficient: the loop unrolls into one adder per set bit of COEF.
    function automatic logic [PW-1:0] shift_add(input logic [WIDTH-1:0] m);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < COEF_FRAC; i++) begin
            if (COEF_V[i]) acc = acc + (PW'(m) << i);
        end
        return acc;
    endfunction

    // COEF < 2^COEF_FRAC keeps the rounded magnitude within 2^(WIDTH-1), so no saturation.
    function automatic logic [WIDTH-1:0] round_restore(input logic [PW-1:0] p, input logic s);
        logic [PW-1:0]    sum;
        logic [WIDTH-1:0] r;
        sum = p + HALF;
        r   = sum[PW-1:COEF_FRAC];
        return s ? (~r + WIDTH'(1)) : r;
    endfunction

    logic             v1_q, v1_d, byp1_q, byp1_d, sx1_q, sx1_d, sy1_q, sy1_d;
    logic [WIDTH-1:0] mx1_q, mx1_d, my1_q, my1_d, x1_q, x1_d, y1_q, y1_d;
    logic             v2_q, v2_d, byp2_q, byp2_d, sx2_q, sx2_d, sy2_q, sy2_d;
    logic [PW-1:0]    px2_q, px2_d, py2_q, py2_d;
    logic [WIDTH-1:0] x2_q, x2_d, y2_q, y2_d;
    logic             v3_q, v3_d;
    logic [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic             en1, en2, en3;

    always_comb begin
        en3    = !v3_q | Out_Ready;
        en2    = !v2_q | en3;
        en1    = !v1_q | en2;
        v1_d   = v1_q;
        byp1_d = byp1_q;
        sx1_d  = sx1_q;
        sy1_d  = sy1_q;
        mx1_d  = mx1_q;
        my1_d  = my1_q;
        x1_d   = x1_q;
        y1_d   = y1_q;
        v2_d   = v2_q;
        byp2_d = byp2_q;
        sx2_d  = sx2_q;
        sy2_d  = sy2_q;
        px2_d  = px2_q;
        py2_d  = py2_q;
        x2_d   = x2_q;
        y2_d   = y2_q;
        v3_d   = v3_q;
        ox_d   = ox_q;
        oy_d   = oy_q;

        if (en1) begin
            v1_d = In_Valid;
            if (In_Valid) begin
                byp1_d = In_Bypass;
                sx1_d  = In_X[WIDTH-1];
                sy1_d  = In_Y[WIDTH-1];
                mx1_d  = abs_mag(In_X);
                my1_d  = abs_mag(In_Y);
                x1_d   = In_X;
                y1_d   = In_Y;
            end
        end

        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                byp2_d = byp1_q;
                sx2_d  = sx1_q;
                sy2_d  = sy1_q;
                px2_d  = shift_add(mx1_q);
                py2_d  = shift_add(my1_q);
                x2_d   = x1_q;
                y2_d   = y1_q;
            end
        end

        // Output data registers only change when a valid pair moves into the last stage.
        if (en3) begin
            v3_d = v2_q;
            if (v2_q) begin
                ox_d = byp2_q ? x2_q : round_restore(px2_q, sx2_q);
                oy_d = byp2_q ? y2_q : round_restore(py2_q, sy2_q);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            v1_q   <= 1'b0;
            byp1_q <= 1'b0;
            sx1_q  <= 1'b0;
            sy1_q  <= 1'b0;
            mx1_q  <= '0;
            my1_q  <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            v2_q   <= 1'b0;
            byp2_q <= 1'b0;
            sx2_q  <= 1'b0;
            sy2_q  <= 1'b0;
            px2_q  <= '0;
            py2_q  <= '0;
            x2_q   <= '0;
            y2_q   <= '0;
            v3_q   <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
        end else begin
            v1_q   <= v1_d;
            byp1_q <= byp1_d;
            sx1_q  <= sx1_d;
            sy1_q  <= sy1_d;
            mx1_q  <= mx1_d;
            my1_q  <= my1_d;
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            v2_q   <= v2_d;
            byp2_q <= byp2_d;
            sx2_q  <= sx2_d;
            sy2_q  <= sy2_d;
            px2_q  <= px2_d;
            py2_q  <= py2_d;
            x2_q   <= x2_d;
            y2_q   <= y2_d;
            v3_q   <= v3_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
        end
    end

    assign In_Ready  = en1;
    assign Out_Valid = v3_q;
    assign Out_X     = ox_q;
    assign Out_Y     = oy_q;

endmodule

// File: tb/tb_cordic_gain_scale.sv
// Directed bench for cordic_gain_scale at default parameters: hand-computed single pairs,
// streaming, backpressure and mid-stream reset, checked against an integer reference.
module tb_cordic_gain_scale;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              In_Valid, In_Ready, In_Bypass;
    logic signed [7:0] In_X, In_Y;
    logic              Out_Valid, Out_Ready;
    logic signed [7:0] Out_X, Out_Y;

    cordic_gain_scale #(.WIDTH(8), .COEF(39797), .COEF_FRAC(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Bypass(In_Bypass),
        .In_X(In_X), .In_Y(In_Y),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_X(Out_X), .Out_Y(Out_Y)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_pop, first_cyc, last_cyc;
    bit sb_en = 1'b0;
    int exp_x[$];
    int exp_y[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Integer reference: round(|v| * 39797 / 65536) half away from zero, sign restored.
    function automatic int ref_scale(input int v);
        int m, r;
        m = (v < 0) ? -v : v;
        r = (m * 39797 + 32768) >>> 16;
        return (v < 0) ? -r : r;
    endfunction

    always @(negedge Clk) begin
        if (!Rst && sb_en) begin
            if (In_Valid && In_Ready) begin
                exp_x.push_back(In_Bypass ? int'(In_X) : ref_scale(int'(In_X)));
                exp_y.push_back(In_Bypass ? int'(In_Y) : ref_scale(int'(In_Y)));
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_x.size() == 0) begin
                    check_eq("sb_extra_output", exp_x.size(), 1);
                end else begin
                    check_eq("sb_x", int'(Out_X), exp_x.pop_front());
                    check_eq("sb_y", int'(Out_Y), exp_y.pop_front());
                    if (n_pop == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n_pop++;
                end
            end
        end
    end

    typedef struct {
        int x; int y; bit byp; int ex; int ey;
    } vec_t;

    vec_t dir_vecs[6] = '{
        '{100, -100, 1'b0,   61,  -61},
        '{127, -128, 1'b0,   77,  -78},
        '{  1,    0, 1'b0,    1,    0},
        '{  4,   -5, 1'b0,    2,   -3},
        '{ -1,    2, 1'b0,   -1,    1},
        '{-128, 127, 1'b1, -128,  127}
    };

    // Pair presented in cycle 0 must show Out_Valid only after the 3rd rising edge.
    task automatic run_one(input vec_t v);
        In_X      = 8'(v.x);
        In_Y      = 8'(v.y);
        In_Bypass = v.byp;
        In_Valid  = 1'b1;
        #1;
        check_eq("dir_in_ready", int'(In_Ready), 1);
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        check_eq("dir_lat1_valid", int'(Out_Valid), 0);
        @(posedge Clk); #1;
        check_eq("dir_lat2_valid", int'(Out_Valid), 0);
        @(posedge Clk); #1;
        check_eq("dir_out_valid", int'(Out_Valid), 1);
        check_eq("dir_out_x", int'(Out_X), v.ex);
        check_eq("dir_out_y", int'(Out_Y), v.ey);
        @(posedge Clk); #1;
        check_eq("dir_valid_drop", int'(Out_Valid), 0);
    endtask

    task automatic sb_clear();
        exp_x.delete();
        exp_y.delete();
        n_pop = 0;
        first_cyc = 0;
        last_cyc = 0;
    endtask

    initial begin
        int k;
        bit acc;
        int hold_x, hold_y;

        Rst = 1'b1; In_Valid = 1'b0; In_Bypass = 1'b0; In_X = '0; In_Y = '0; Out_Ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        check_eq("rst_out_valid", int'(Out_Valid), 0);
        check_eq("rst_out_x", int'(Out_X), 0);
        check_eq("rst_out_y", int'(Out_Y), 0);
        check_eq("rst_in_ready", int'(In_Ready), 1);

        foreach (dir_vecs[i]) run_one(dir_vecs[i]);

        // Streaming: 20 back-to-back pairs, downstream always ready.
        sb_clear();
        sb_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            In_X      = 8'($urandom_range(0, 255));
            In_Y      = 8'($urandom_range(0, 255));
            In_Bypass = ($urandom_range(0, 3) == 0);
            In_Valid  = 1'b1;
            #1;
            check_eq("st_in_ready", int'(In_Ready), 1);
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        check_eq("st_pop_count", n_pop, 20);
        check_eq("st_consecutive", last_cyc - first_cyc, 19);
        check_eq("st_leftover", exp_x.size(), 0);
        sb_en = 1'b0;

        // Backpressure: Out_Ready low for cycles 2..7 of a 10-pair stream.
        sb_clear();
        sb_en = 1'b1;
        k = 0;
        hold_x = 0;
        hold_y = 0;
        for (int c = 0; c < 40; c++) begin
            Out_Ready = !(c >= 2 && c < 8);
            if (k < 10) begin
                In_X      = 8'($urandom_range(0, 255));
                In_Y      = 8'($urandom_range(0, 255));
                In_Bypass = ($urandom_range(0, 4) == 0);
                In_Valid  = 1'b1;
            end else begin
                In_Valid = 1'b0;
            end
            #1;
            acc = In_Valid && In_Ready;
            if (c == 3) begin
                check_eq("bp_valid_held", int'(Out_Valid), 1);
                hold_x = int'(Out_X);
                hold_y = int'(Out_Y);
            end
            if (c > 3 && c < 8) begin
                check_eq("bp_stable_valid", int'(Out_Valid), 1);
                check_eq("bp_stable_x", int'(Out_X), hold_x);
                check_eq("bp_stable_y", int'(Out_Y), hold_y);
            end
            if (c == 7) begin
                check_eq("bp_in_flight", exp_x.size(), 3);
                check_eq("bp_in_ready_low", int'(In_Ready), 0);
            end
            @(posedge Clk); #1;
            if (acc) k++;
        end
        Out_Ready = 1'b1;
        check_eq("bp_accepted", k, 10);
        check_eq("bp_pop_count", n_pop, 10);
        check_eq("bp_leftover", exp_x.size(), 0);
        sb_en = 1'b0;

        // Reset with two pairs in flight: they must never emerge.
        Out_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            In_X = 8'(50 + i); In_Y = 8'(-60 - i); In_Bypass = 1'b0; In_Valid = 1'b1;
            #1;
            check_eq("rs_in_ready", int'(In_Ready), 1);
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check_eq("rs_out_valid", int'(Out_Valid), 0);
        check_eq("rs_out_x", int'(Out_X), 0);
        check_eq("rs_out_y", int'(Out_Y), 0);
        check_eq("rs_in_ready", int'(In_Ready), 1);
        Out_Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            check_eq("rs_no_ghost", int'(Out_Valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
